// File: rtl/multu_seq_unit.sv
// Sequential unsigned WIDTHxWIDTH multiplier with HI/LO result registers.
// Shift-add, one multiplier bit per cycle; MFHI/MFLO served via op.
module multu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] data_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MFHI = 3'b100;
    localparam logic [2:0] OP_MFLO = 3'b101;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic             start_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [AW-1:0]    acc_q, acc_d;

    logic             launch;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   upper;
    logic [AW-1:0]    acc_step;

    // Launch only on a fresh rising edge of the level enable.
    assign launch = (state_q == S_IDLE) && start && !start_q;

    // Upper half keeps its carry; the shift pulls it back into range.
    always_comb begin
        addend   = acc_q[0] ? {1'b0, mcand_q} : '0;
        upper    = acc_q[AW-1:WIDTH] + addend;
        acc_step = {upper, acc_q[WIDTH-1:0]} >> 1;
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        count_d = count_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    mcand_d = a;
                    acc_d   = {{(WIDTH + 1){1'b0}}, b};
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = acc_step;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    hi_d    = acc_step[2*WIDTH-1:WIDTH];
                    lo_d    = acc_step[WIDTH-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        data_out = '0;
        if (op == OP_MFHI) begin
            data_out = hi_q;
        end else if (op == OP_MFLO) begin
            data_out = lo_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_multu_seq_unit.sv
// Scoreboard bench for multu_seq_unit: directed vectors plus
// random operand pairs checked against a 64-bit product.
module tb_multu_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] data_out;

    logic [63:0] exp_q[$];
    int          n_vec  = 0;
    int          n_err  = 0;
    int          n_done = 0;
    logic        done_prev = 1'b0;

    multu_seq_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .op       (op),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            chk("done_single_cycle", {63'b0, done_prev}, 64'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: hi=%h lo=%h with nothing pending",
                         hi, lo);
            end else begin
                chk("product", {hi, lo}, exp_q.pop_front());
            end
        end
        done_prev = done && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int lim, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < lim);
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", lim);
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] e, output int lat);
        start = 1'b0;
        tick();
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        wait_done(40, lat);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          d0;
        logic [31:0] x;
        logic [31:0] y;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = 3'b000;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_busy_done", {62'b0, busy, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 3*5 with latency and post-done checks
        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, lat);
        chk("t1_latency", 64'(lat), 64'd33);
        chk("t1_busy_at_done", {63'b0, busy}, 64'd0);
        op = 3'b101;
        #1;
        chk("t1_mflo", {32'b0, data_out}, 64'h0F);
        @(negedge clk);
        chk("t1_done_cleared", {62'b0, busy, done}, 64'd0);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, lat);
        chk("t2_latency", 64'(lat), 64'd33);

        run_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, lat);
        op = 3'b100;
        #1;
        chk("t3_mfhi", {32'b0, data_out}, 64'd1);
        op = 3'b101;
        #1;
        chk("t3_mflo", {32'b0, data_out}, 64'd0);
        op = 3'b010;
        #1;
        chk("t3_noread", {32'b0, data_out}, 64'd0);

        // 7*6 with start held, operand change and re-pulse while busy
        start = 1'b0;
        tick();
        d0    = n_done;
        a     = 32'd7;
        b     = 32'd6;
        start = 1'b1;
        exp_q.push_back(64'd42);
        tick();
        repeat (9) tick();
        a     = 32'h0000_FFFF;
        b     = 32'h0001_0001;
        start = 1'b0;
        op    = 3'b100;
        @(negedge clk);
        chk("t4_run_busy", {63'b0, busy}, 64'd1);
        chk("t4_run_old_hi", {32'b0, data_out}, 64'd1);
        tick();
        start = 1'b1;
        repeat (30) tick();
        chk("t4_one_done", 64'(n_done - d0), 64'd1);
        chk("t4_hilo", {hi, lo}, 64'd42);
        start = 1'b0;
        op    = 3'b000;

        // reset mid-operation discards the result
        tick();
        d0    = n_done;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy_done", {62'b0, busy, done}, 64'd0);
        chk("t5_hilo", {hi, lo}, 64'd0);
        repeat (40) tick();
        chk("t5_no_done", 64'(n_done - d0), 64'd0);

        // back-to-back: held start, drop one cycle, relaunch
        start = 1'b0;
        tick();
        a     = 32'hFFFF_FFFF;
        b     = 32'd3;
        start = 1'b1;
        exp_q.push_back(64'h0000_0002_FFFF_FFFD);
        tick();
        wait_done(40, lat);
        start = 1'b0;
        a     = 32'd0;
        b     = 32'hDEAD_BEEF;
        exp_q.push_back(64'd0);
        tick();
        start = 1'b1;
        tick();
        wait_done(40, lat);
        chk("t6_latency", 64'(lat), 64'd33);

        // launch in the done cycle itself
        start = 1'b0;
        run_op(32'd1000, 32'd1000, 64'd1000000, lat);
        a     = 32'h0001_0000;
        b     = 32'h0001_0000;
        start = 1'b1;
        exp_q.push_back(64'h0000_0001_0000_0000);
        tick();
        start = 1'b0;
        wait_done(40, lat);
        chk("t7_done_cycle_launch", 64'(lat), 64'd33);

        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            run_op(x, y, {32'b0, x} * {32'b0, y}, lat);
        end

        repeat (3) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
